// File: rtl/rram_write_verify_ctrl.sv
// rram_write_verify_ctrl
// Program-and-verify controller for a single RRAM cell. It accepts READ, SET
// and RESET commands, drives the cell's pulse driver (enable, polarity,
// amplitude), samples cell current through an ADC start/done handshake and
// applies incremental-step program pulses until the current crosses the
// target or the pulse budget is spent. Exactly one response per command.
//
// Ports
//   clk, rst                  clock (rising edge), async active-high reset
//   cmd_valid/cmd_ready       command handshake
//   cmd_op                    00 READ, 01 SET, 10 RESET, 11 illegal
//   cmd_target                verify threshold (ADC code)
//   drv_en/drv_pol/drv_amp    registered pulse-driver controls
//   adc_start                 one-cycle conversion request
//   adc_done/adc_data         conversion complete, sampled current code
//   rsp_valid/rsp_ready       response handshake (held under backpressure)
//   rsp_status                00 pass, 01 budget exhausted, 10 illegal op
//   rsp_pulses                program pulses applied
//   rsp_data                  last captured ADC code (0 if none)
module rram_write_verify_ctrl #(
    parameter int AW           = 8,
    parameter int CW           = 10,
    parameter int PW           = 16,
    parameter int SETTLE       = 4,
    parameter int MAX_PULSES   = 15,
    parameter int V_SET_INIT   = 64,
    parameter int V_RESET_INIT = 64,
    parameter int V_STEP       = 4,
    parameter int V_READ       = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [CW-1:0] cmd_target,
    output logic          drv_en,
    output logic          drv_pol,
    output logic [AW-1:0] drv_amp,
    output logic          adc_start,
    input  logic          adc_done,
    input  logic [CW-1:0] adc_data,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [1:0]    rsp_status,
    output logic [3:0]    rsp_pulses,
    output logic [CW-1:0] rsp_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ_START,
        S_READ_WAIT,
        S_CHECK,
        S_PULSE,
        S_SETTLE,
        S_RESP
    } state_t;

    localparam logic [1:0] OP_READ    = 2'b00;
    localparam logic [1:0] OP_SET     = 2'b01;
    localparam logic [1:0] OP_RESET   = 2'b10;
    localparam logic [1:0] OP_ILLEGAL = 2'b11;

    localparam int TMAX = (PW > SETTLE) ? PW : SETTLE;
    localparam int TW   = $clog2(TMAX + 1);

    state_t        state, next_state;
    logic [1:0]    op_q;
    logic [CW-1:0] target_q;
    logic [CW-1:0] data_q;
    logic [AW-1:0] amp_q;
    logic [3:0]    count_q;
    logic [TW-1:0] timer_q;
    logic [AW:0]   amp_sum;
    logic          verify_pass;

    // One extra bit catches the carry so the step saturates instead of wrapping.
    assign amp_sum = {1'b0, amp_q} + (AW+1)'(V_STEP);

    assign verify_pass = (op_q == OP_READ)
                      || ((op_q == OP_SET)   && (data_q >= target_q))
                      || ((op_q == OP_RESET) && (data_q <= target_q));

    assign cmd_ready  = (state == S_IDLE);
    assign rsp_pulses = count_q;
    assign rsp_data   = data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            // NOTE: registers take non-blocking assignments so every flop
            // samples pre-edge values, independent of block ordering.
            state <= next_state;
        end
    end

    always_comb begin
        // NOTE: defaulting next_state first keeps every path assigned, so no
        // latch is inferred for states that simply wait.
        next_state = state;
        unique case (state)
            S_IDLE:       if (cmd_valid) next_state = (cmd_op == OP_ILLEGAL) ? S_RESP : S_READ_START;
            S_READ_START: next_state = S_READ_WAIT;
            S_READ_WAIT:  if (adc_done) next_state = S_CHECK;
            S_CHECK:      next_state = (verify_pass || (count_q == 4'(MAX_PULSES))) ? S_RESP : S_PULSE;
            S_PULSE:      if (timer_q == TW'(PW - 1)) next_state = S_SETTLE;
            S_SETTLE:     if (timer_q == TW'(SETTLE - 1)) next_state = S_READ_START;
            S_RESP:       if (rsp_ready) next_state = S_IDLE;
            default:      next_state = S_IDLE;
        endcase
    end

    // Datapath and registered driver/ADC/response controls. Outputs are
    // decoded from next_state so they are flops aligned with the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the async reset clears drv_en directly, so a reset in the
            // middle of a program pulse removes bias immediately, not at an edge.
            op_q       <= OP_READ;
            target_q   <= '0;
            data_q     <= '0;
            amp_q      <= '0;
            count_q    <= '0;
            timer_q    <= '0;
            rsp_status <= 2'b00;
            drv_en     <= 1'b0;
            drv_pol    <= 1'b0;
            drv_amp    <= '0;
            adc_start  <= 1'b0;
            rsp_valid  <= 1'b0;
        end else begin
            // Per-state dwell counter, restarted on every state change.
            timer_q <= (next_state == state) ? timer_q + TW'(1) : '0;

            if (state == S_IDLE && cmd_valid) begin
                op_q       <= cmd_op;
                target_q   <= cmd_target;
                data_q     <= '0;
                count_q    <= '0;
                amp_q      <= (cmd_op == OP_RESET) ? AW'(V_RESET_INIT) : AW'(V_SET_INIT);
                rsp_status <= (cmd_op == OP_ILLEGAL) ? 2'b10 : 2'b00;
            end

            if (state == S_READ_WAIT && adc_done) begin
                data_q <= adc_data;
            end

            if (state == S_CHECK) begin
                rsp_status <= verify_pass ? 2'b00 : 2'b01;
                if (next_state == S_PULSE) begin
                    count_q <= count_q + 4'd1;
                end
            end

            if (state == S_PULSE && next_state == S_SETTLE) begin
                amp_q <= amp_sum[AW] ? '1 : amp_sum[AW-1:0];
            end

            drv_en    <= (next_state == S_READ_START) || (next_state == S_READ_WAIT)
                      || (next_state == S_PULSE);
            adc_start <= (next_state == S_READ_START);
            rsp_valid <= (next_state == S_RESP);

            // Polarity moves to the program direction on entry to CHECK and back
            // to read polarity on leaving PULSE; both happen with the driver off.
            drv_pol <= ((next_state == S_CHECK) || (next_state == S_PULSE))
                     ? (op_q != OP_RESET) : 1'b1;

            unique case (next_state)
                S_READ_START, S_READ_WAIT: drv_amp <= AW'(V_READ);
                S_PULSE:                   drv_amp <= amp_q;
                default:                   drv_amp <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_rram_write_verify_ctrl.sv
// tb_rram_write_verify_ctrl
// Self-checking bench: directed scenarios plus randomized commands, all
// compared against a behavioural model of the program-and-verify algorithm.
module tb_rram_write_verify_ctrl;

    localparam int AW           = 8;
    localparam int CW           = 10;
    localparam int PW           = 16;
    localparam int SETTLE       = 4;
    localparam int MAX_PULSES   = 15;
    localparam int V_SET_INIT   = 64;
    localparam int V_RESET_INIT = 64;
    localparam int V_STEP       = 20;
    localparam int V_READ       = 16;
    localparam int AMP_MAX      = (1 << AW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [CW-1:0] cmd_target;
    logic          drv_en;
    logic          drv_pol;
    logic [AW-1:0] drv_amp;
    logic          adc_start;
    logic          adc_done;
    logic [CW-1:0] adc_data;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [1:0]    rsp_status;
    logic [3:0]    rsp_pulses;
    logic [CW-1:0] rsp_data;

    rram_write_verify_ctrl #(
        .AW(AW), .CW(CW), .PW(PW), .SETTLE(SETTLE), .MAX_PULSES(MAX_PULSES),
        .V_SET_INIT(V_SET_INIT), .V_RESET_INIT(V_RESET_INIT),
        .V_STEP(V_STEP), .V_READ(V_READ)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_target(cmd_target),
        .drv_en(drv_en), .drv_pol(drv_pol), .drv_amp(drv_amp),
        .adc_start(adc_start), .adc_done(adc_done), .adc_data(adc_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_status(rsp_status), .rsp_pulses(rsp_pulses), .rsp_data(rsp_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- ADC responder ----------------
    // Answers each adc_start after a delay with the next value of adc_vals
    // (the last value repeats). While idle it can emit stray adc_done pulses.
    int adc_vals[$];
    int adc_fixed_delay = 0;
    bit stray_enable = 1'b0;

    initial begin
        int idx;
        int d;
        idx = 0;
        adc_done = 1'b0;
        adc_data = '0;
        forever begin
            @(negedge clk);
            adc_done = 1'b0;
            if (cmd_ready) begin
                idx = 0;
                if (stray_enable && !rst) begin
                    adc_done = 1'($urandom_range(0, 1));
                    adc_data = CW'($urandom);
                end
            end else if (adc_start && !rst) begin
                d = (adc_fixed_delay > 0) ? adc_fixed_delay : int'($urandom_range(1, 4));
                repeat (d) @(negedge clk);
                adc_data = CW'(adc_vals[(idx < adc_vals.size()) ? idx : adc_vals.size() - 1]);
                adc_done = 1'b1;
                idx++;
            end
        end
    end

    // ---------------- Driver monitor ----------------
    // Splits drv_en activity into read segments (begin with adc_start) and
    // program pulses; records pulse amp/length/polarity and the gaps that
    // follow. Restarts its record on every command acceptance.
    int  n_adc_start;
    int  pulse_amp_q[$];
    int  pulse_len_q[$];
    int  pulse_pol_q[$];
    int  gap_q[$];
    int  pol_glitch, read_bad, seg_bad;
    bit  prev_en, prev_pol, prev_ready;
    bit  in_seg, seg_read, gap_on;
    int  seg_len, seg_amp, seg_pol, gap_len;

    always @(negedge clk) begin
        if (rst) begin
            prev_en    = 1'b0;
            prev_pol   = drv_pol;
            prev_ready = cmd_ready;
            in_seg     = 1'b0;
            gap_on     = 1'b0;
        end else begin
            if (prev_ready && !cmd_ready) begin
                n_adc_start = 0;
                pulse_amp_q.delete();
                pulse_len_q.delete();
                pulse_pol_q.delete();
                gap_q.delete();
                pol_glitch = 0;
                read_bad   = 0;
                seg_bad    = 0;
                gap_on     = 1'b0;
            end
            if (adc_start) n_adc_start++;
            if (drv_en && (drv_pol != prev_pol)) pol_glitch++;
            if (drv_en && !prev_en) begin
                if (gap_on) begin
                    gap_q.push_back(gap_len);
                    gap_on = 1'b0;
                end
                in_seg   = 1'b1;
                seg_read = adc_start;
                seg_len  = 1;
                seg_amp  = int'(drv_amp);
                seg_pol  = int'(drv_pol);
                if (seg_read && (seg_amp != V_READ || seg_pol != 1)) read_bad++;
            end else if (drv_en) begin
                seg_len++;
                if (int'(drv_amp) != seg_amp || int'(drv_pol) != seg_pol) seg_bad++;
            end else if (prev_en) begin
                in_seg = 1'b0;
                if (!seg_read) begin
                    pulse_amp_q.push_back(seg_amp);
                    pulse_len_q.push_back(seg_len);
                    pulse_pol_q.push_back(seg_pol);
                    gap_on  = 1'b1;
                    gap_len = 0;
                end
            end
            if (!drv_en && gap_on) gap_len++;
            prev_en    = drv_en;
            prev_pol   = drv_pol;
            prev_ready = cmd_ready;
        end
    end

    // ---------------- Reference model ----------------
    // Program-and-verify loop: read, stop on pass or spent budget, else pulse
    // at INIT + k*STEP (clipped to the amplitude range) and read again.
    int exp_status, exp_pulses, exp_data, exp_reads;
    int exp_amps[$];

    task automatic model(input int op, input int target);
        int v;
        int k;
        exp_amps.delete();
        exp_pulses = 0;
        exp_reads  = 0;
        exp_data   = 0;
        if (op == 3) begin
            exp_status = 2;
            return;
        end
        k = 0;
        forever begin
            v = adc_vals[(k < adc_vals.size()) ? k : adc_vals.size() - 1];
            k++;
            exp_reads++;
            exp_data = v;
            if (op == 0 || (op == 1 && v >= target) || (op == 2 && v <= target)) begin
                exp_status = 0;
                break;
            end
            if (exp_pulses == MAX_PULSES) begin
                exp_status = 1;
                break;
            end
            begin
                int a;
                a = ((op == 2) ? V_RESET_INIT : V_SET_INIT) + exp_pulses * V_STEP;
                exp_amps.push_back((a > AMP_MAX) ? AMP_MAX : a);
            end
            exp_pulses++;
        end
    endtask

    // ---------------- Command runner ----------------
    task automatic run_cmd(input int op, input int target, input int hold);
        bit got;
        bit held_ok;
        model(op, target);
        @(negedge clk);
        check("cmd_ready_idle", cmd_ready, 1);
        cmd_valid  = 1'b1;
        cmd_op     = 2'(op);
        cmd_target = CW'(target);
        @(negedge clk);
        cmd_valid  = 1'b0;
        cmd_op     = 2'($urandom);
        cmd_target = CW'($urandom);
        check("cmd_ready_busy", cmd_ready, 0);

        got = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("rsp_seen", got, 1);
        if (!got) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
            return;
        end

        check("rsp_status", rsp_status, exp_status);
        check("rsp_pulses", rsp_pulses, exp_pulses);
        check("rsp_data", rsp_data, exp_data);
        held_ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!rsp_valid || rsp_status != 2'(exp_status) || rsp_pulses != 4'(exp_pulses)
                || rsp_data != CW'(exp_data) || cmd_ready || drv_en) held_ok = 1'b0;
        end
        if (hold > 0) check("rsp_held_stable", held_ok, 1);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("cmd_ready_after_rsp", cmd_ready, 1);
        check("rsp_valid_dropped", rsp_valid, 0);

        #1;
        check("adc_start_count", n_adc_start, exp_reads);
        check("pulse_count", pulse_amp_q.size(), exp_amps.size());
        check("gap_count", gap_q.size(), exp_amps.size());
        for (int i = 0; i < exp_amps.size() && i < pulse_amp_q.size(); i++) begin
            check("pulse_amp", pulse_amp_q[i], exp_amps[i]);
            check("pulse_len", pulse_len_q[i], PW);
            check("pulse_pol", pulse_pol_q[i], (op == 1) ? 1 : 0);
        end
        for (int i = 0; i < gap_q.size(); i++) begin
            check("settle_len", gap_q[i], SETTLE);
        end
        check("pol_change_while_en", pol_glitch, 0);
        check("read_bias_bad", read_bad, 0);
        check("segment_unstable", seg_bad, 0);
    endtask

    // Watchdog: a hung run still reports and stops.
    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_op     = 2'b00;
        cmd_target = '0;
        rsp_ready  = 1'b0;
        adc_vals   = '{0};

        repeat (3) @(negedge clk);
        check("rst_drv_en", drv_en, 0);
        check("rst_drv_pol", drv_pol, 0);
        check("rst_drv_amp", drv_amp, 0);
        check("rst_adc_start", adc_start, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_status", rsp_status, 0);
        check("rst_rsp_pulses", rsp_pulses, 0);
        check("rst_rsp_data", rsp_data, 0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        repeat (2) @(negedge clk);

        // READ: one conversion, answer after 3 cycles.
        adc_fixed_delay = 3;
        adc_vals = '{300};
        run_cmd(0, 0, 0);
        adc_fixed_delay = 0;

        // SET converging after three pulses.
        adc_vals = '{100, 200, 450, 520};
        run_cmd(1, 500, 2);

        // RESET never reaches target: full budget, amplitude saturates.
        adc_vals = '{400};
        run_cmd(2, 50, 1);

        // SET already satisfied: no pulse.
        adc_vals = '{900};
        run_cmd(1, 200, 0);

        // Stray adc_done while idle must be ignored.
        stray_enable = 1'b1;
        found = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (!cmd_ready || rsp_valid || drv_en || adc_start) found = 1'b0;
        end
        stray_enable = 1'b0;
        check("stray_adc_done_ignored", found, 1);

        // Illegal op: response held under 10 cycles of backpressure.
        adc_vals = '{0};
        run_cmd(3, 123, 10);

        // Reset during the 5th cycle of a program pulse.
        adc_vals = '{0};
        @(negedge clk);
        cmd_valid  = 1'b1;
        cmd_op     = 2'b01;
        cmd_target = CW'(1000);
        @(negedge clk);
        cmd_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            #1;
            if (in_seg && !seg_read && seg_len == 5) begin
                found = 1'b1;
                break;
            end
        end
        check("mid_pulse_reached", found, 1);
        check("mid_pulse_drv_en", drv_en, 1);
        check("mid_pulse_count", rsp_pulses, 1);
        rst = 1'b1;
        #1;
        check("rst_mid_drv_en", drv_en, 0);
        check("rst_mid_drv_pol", drv_pol, 0);
        check("rst_mid_drv_amp", drv_amp, 0);
        check("rst_mid_adc_start", adc_start, 0);
        check("rst_mid_rsp_valid", rsp_valid, 0);
        check("rst_mid_rsp_status", rsp_status, 0);
        check("rst_mid_rsp_pulses", rsp_pulses, 0);
        check("rst_mid_rsp_data", rsp_data, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_cmd_ready", cmd_ready, 1);
        check("rst_mid_idle_drv_en", drv_en, 0);

        // Randomized commands against the model.
        for (int n = 0; n < 20; n++) begin
            int nv;
            adc_vals.delete();
            nv = int'($urandom_range(1, 6));
            for (int j = 0; j < nv; j++) adc_vals.push_back(int'($urandom_range(0, (1 << CW) - 1)));
            run_cmd(int'($urandom_range(0, 3)), int'($urandom_range(0, (1 << CW) - 1)),
                    int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
